// File: rtl/lifo_stack_pkg.sv
// -----------------------------------------------------------------------------
// lifo_stack_pkg
// Shared definitions for the LIFO stack: the command encoding carried on the
// 2-bit op port of lifo_stack.
// -----------------------------------------------------------------------------
package lifo_stack_pkg;

    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10,
        OP_PEEK = 2'b11
    } op_e;

endpackage : lifo_stack_pkg

// File: rtl/lifo_stack_ram.sv
// -----------------------------------------------------------------------------
// lifo_stack_ram
// DW x DEPTH storage for the LIFO stack: one synchronous write port and one
// synchronous read port. The array itself is never reset; only the read
// register is, so the stack's data_out reads 0 straight out of reset.
//
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous active-high reset (read register only)
//   wr_en    in   write strobe
//   wr_addr  in   write index
//   wr_data  in   write word
//   rd_en    in   read strobe; rd_data holds its value while low
//   rd_addr  in   read index
//   rd_data  out  registered read word
// -----------------------------------------------------------------------------
module lifo_stack_ram #(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_data_reg;

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register, kept separate from the array so only it sees reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_reg;

endmodule : lifo_stack_ram

// File: rtl/lifo_stack.sv
// -----------------------------------------------------------------------------
// lifo_stack
// Parameterised LIFO stack with PUSH / POP / PEEK commands, occupancy flags,
// overflow / underflow pulses and optional sticky error flags.
//
// Optional feature macro: LIFO_STACK_ERR_STICKY_EN
//   defined   -> err_ovf / err_unf latch ovf / unf events until err_clr
//   undefined -> err_ovf / err_unf tied to 0, err_clr ignored
//
// Ports:
//   clk         in   clock, rising edge
//   rst         in   asynchronous active-high reset
//   enable      in   command qualifier
//   op          in   command (lifo_stack_pkg::op_e encoding)
//   data_in     in   word written on PUSH
//   err_clr     in   clears sticky error flags
//   data_out    out  result of the last successful POP / PEEK
//   dout_valid  out  one-cycle pulse after data_out was loaded
//   count       out  occupancy 0..DEPTH
//   full/empty/afull  out  occupancy flags, decoded from count
//   ovf / unf   out  overflow / underflow event pulses
//   err_ovf / err_unf out sticky error flags
// -----------------------------------------------------------------------------
module lifo_stack
    import lifo_stack_pkg::*;
#(
    parameter int DW    = 16,
    parameter int DEPTH = 16,
    parameter int AFULL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [1:0]                 op,
    input  logic [DW-1:0]              data_in,
    input  logic                       err_clr,
    output logic [DW-1:0]              data_out,
    output logic                       dout_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output logic                       afull,
    output logic                       ovf,
    output logic                       unf,
    output logic                       err_ovf,
    output logic                       err_unf
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic          dout_valid_reg;
    logic          ovf_reg;
    logic          unf_reg;

    logic          push_ok;
    logic          pop_ok;
    logic          rd_ok;
    logic          ovf_evt;
    logic          unf_evt;

    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign afull = (count_reg >= CW'(AFULL));

    // Command decode. A blocked command turns into an event pulse and
    // touches neither memory nor count.
    always_comb begin
        push_ok = 1'b0;
        pop_ok  = 1'b0;
        rd_ok   = 1'b0;
        ovf_evt = 1'b0;
        unf_evt = 1'b0;
        if (enable) begin
            case (op_e'(op))
                OP_PUSH: begin
                    if (!full) push_ok = 1'b1;
                    else       ovf_evt = 1'b1;
                end
                OP_POP: begin
                    if (!empty) begin
                        rd_ok  = 1'b1;
                        pop_ok = 1'b1;
                    end else begin
                        unf_evt = 1'b1;
                    end
                end
                OP_PEEK: begin
                    if (!empty) rd_ok   = 1'b1;
                    else        unf_evt = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Push and pop are mutually exclusive, so count moves by at most one
    // and is held inside 0..DEPTH by the full/empty guards above.
    always_comb begin
        count_next = count_reg;
        if (push_ok)     count_next = count_reg + CW'(1);
        else if (pop_ok) count_next = count_reg - CW'(1);
    end

    // Addresses are truncated to AW bits; the out-of-range values (write at
    // DEPTH, read at -1) only occur when the strobe is blocked.
    assign wr_addr = AW'(count_reg);
    assign rd_addr = AW'(count_reg - CW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg      <= '0;
            dout_valid_reg <= 1'b0;
            ovf_reg        <= 1'b0;
            unf_reg        <= 1'b0;
        end else begin
            count_reg      <= count_next;
            dout_valid_reg <= rd_ok;
            ovf_reg        <= ovf_evt;
            unf_reg        <= unf_evt;
        end
    end

    // The RAM read register doubles as data_out: it loads only on a
    // successful read and resets to zero.
    lifo_stack_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (push_ok),
        .wr_addr (wr_addr),
        .wr_data (data_in),
        .rd_en   (rd_ok),
        .rd_addr (rd_addr),
        .rd_data (data_out)
    );

`ifdef LIFO_STACK_ERR_STICKY_EN
    logic err_ovf_reg;
    logic err_unf_reg;

    // Set has priority over clear when both land on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_reg <= 1'b0;
            err_unf_reg <= 1'b0;
        end else begin
            err_ovf_reg <= ovf_evt | (err_ovf_reg & ~err_clr);
            err_unf_reg <= unf_evt | (err_unf_reg & ~err_clr);
        end
    end

    assign err_ovf = err_ovf_reg;
    assign err_unf = err_unf_reg;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_ovf        = 1'b0;
    assign err_unf        = 1'b0;
`endif

    assign count      = count_reg;
    assign dout_valid = dout_valid_reg;
    assign ovf        = ovf_reg;
    assign unf        = unf_reg;

endmodule : lifo_stack
